// File: rtl/lumi_tx_arb_ser.sv
// lumi_tx_arb_ser: multi-channel LUMI transmit serializer.
// Round-robin arbitration across NCH UMI inputs, one full transaction latched
// per grant, then streamed to a ready/valid PHY link in beats whose byte width
// is chosen at grant time and held for the whole packet.
module lumi_tx_arb_ser #(
   parameter  int NCH = 2,                              // UMI input channels
   parameter  int IOW = 64,                             // PHY data width (bits)
   parameter  int DW  = 128,                            // UMI data width
   parameter  int CW  = 32,                             // UMI command width
   parameter  int AW  = 64,                             // UMI address width
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1     // channel-ID width
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              csr_en,
   input  logic [7:0]        csr_iowidth,
   input  logic [NCH-1:0]    umi_in_valid,
   input  logic [NCH*CW-1:0] umi_in_cmd,
   input  logic [NCH*AW-1:0] umi_in_dstaddr,
   input  logic [NCH*AW-1:0] umi_in_srcaddr,
   input  logic [NCH*DW-1:0] umi_in_data,
   output logic [NCH-1:0]    umi_in_ready,
   output logic [IOW-1:0]    phy_txdata,
   output logic              phy_txvld,
   input  logic              phy_txrdy,
   output logic [CHW-1:0]    phy_txch,
   output logic              phy_txlast
);

   // Packet geometry: cmd, dstaddr, srcaddr, data packed from the LSB up.
   localparam int PKW  = CW + 2*AW + DW;
   localparam int PB   = PKW / 8;
   // The shift register is at least one beat wide so the low beat slice
   // always exists, even for packets shorter than the PHY.
   localparam int SRW  = (PKW > IOW) ? PKW : IOW;
   localparam int MAXL = $clog2(IOW / 8);
   localparam int LW   = (MAXL > 0) ? $clog2(MAXL + 1) : 1;
   localparam int CNTW = $clog2(PB + 1);

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_e;

   // Byte-lane mask keeping the low 2^l bytes of a beat.
   function automatic logic [IOW-1:0] beat_mask(input logic [LW-1:0] l);
      logic [IOW-1:0] m;
      m = '0;
      for (int i = 0; i < IOW/8; i++) begin
         if (i < (1 << l)) m[8*i +: 8] = 8'hFF;
      end
      return m;
   endfunction

   // Beats per packet minus one: ceil(PB / 2^l) - 1.
   function automatic logic [CNTW-1:0] beats_m1(input logic [LW-1:0] l);
      return CNTW'(((PB + (1 << l) - 1) >> l) - 1);
   endfunction

   state_e          state_q;
   logic [CHW-1:0]  rr_q;
   logic [SRW-1:0]  sr_q;
   logic [CNTW-1:0] cnt_q;
   logic [LW-1:0]   bbl_q;
   logic [IOW-1:0]  data_q;
   logic            vld_q;
   logic            last_q;
   logic [CHW-1:0]  ch_q;

   logic            any_valid;
   logic [CHW-1:0]  grant;
   logic [CHW-1:0]  rr_d;
   logic            handshake;
   logic [LW-1:0]   req_l;
   logic [PKW-1:0]  grant_pkt;
   logic [SRW-1:0]  grant_sr;
   logic [CNTW-1:0] grant_nbm1;
   logic [SRW-1:0]  sr_shift;

   // Clamp the requested beat width to what the PHY can carry.
   always_comb begin
      if (csr_iowidth > 8'(MAXL)) req_l = LW'(MAXL);
      else                        req_l = csr_iowidth[LW-1:0];
   end

   // Round-robin search: first valid channel at or after rr_q, with wrap.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // otherwise paths that skip an assignment infer a latch.
      logic found;
      logic [CHW:0] idx;
      logic [NCH-1:0] rot;
      any_valid = |umi_in_valid;
      grant     = rr_q;
      found     = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         idx = {1'b0, rr_q} + (CHW+1)'(i);
         if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
         rot = umi_in_valid >> idx;
         if (!found && rot[0]) begin
            grant = idx[CHW-1:0];
            found = 1'b1;
         end
      end
   end

   // Pointer advance and transaction mux for the granted channel.
   always_comb begin
      if (grant == CHW'(NCH - 1)) rr_d = '0;
      else                        rr_d = grant + CHW'(1);
      grant_pkt = '0;
      for (int c = 0; c < NCH; c++) begin
         if (grant == CHW'(c)) begin
            grant_pkt = {umi_in_data[c*DW +: DW], umi_in_srcaddr[c*AW +: AW],
                         umi_in_dstaddr[c*AW +: AW], umi_in_cmd[c*CW +: CW]};
         end
      end
      grant_sr   = SRW'(grant_pkt);
      grant_nbm1 = beats_m1(req_l);
   end

   // Ready is offered only to the winner, only while idle and enabled.
   always_comb begin
      handshake = (state_q == ST_IDLE) && csr_en && any_valid;
      if (handshake && !reset) umi_in_ready = NCH'(1) << grant;
      else                     umi_in_ready = '0;
   end

   // Next shift-register contents after the current beat is consumed.
   always_comb begin
      sr_shift = sr_q >> (8 << bbl_q);
   end

   // Transmit FSM: latch a transaction on grant, then drain it beat by beat.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         bbl_q   <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         ch_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (handshake) begin
                  sr_q    <= grant_sr;
                  data_q  <= grant_sr[IOW-1:0] & beat_mask(req_l);
                  bbl_q   <= req_l;
                  cnt_q   <= grant_nbm1;
                  last_q  <= (grant_nbm1 == '0);
                  vld_q   <= 1'b1;
                  ch_q    <= grant;
                  rr_q    <= rr_d;
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (phy_txrdy) begin
                  if (cnt_q == '0) begin
                     vld_q   <= 1'b0;
                     last_q  <= 1'b0;
                     data_q  <= '0;
                     sr_q    <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     sr_q   <= sr_shift;
                     data_q <= sr_shift[IOW-1:0] & beat_mask(bbl_q);
                     cnt_q  <= cnt_q - CNTW'(1);
                     last_q <= (cnt_q == CNTW'(1));
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign phy_txdata = data_q;
   assign phy_txvld  = vld_q;
   assign phy_txlast = last_q;
   assign phy_txch   = ch_q;

endmodule

// File: tb/tb_lumi_tx_arb_ser.sv
// Directed bench for lumi_tx_arb_ser with default parameters (NCH=2, IOW=64).
module tb_lumi_tx_arb_ser;

   localparam int NCH = 2;
   localparam int IOW = 64;
   localparam int DW  = 128;
   localparam int CW  = 32;
   localparam int AW  = 64;
   localparam int CHW = 1;
   localparam int PKW = CW + 2*AW + DW;
   localparam int PB  = PKW / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              csr_en;
   logic [7:0]        csr_iowidth;
   logic [NCH-1:0]    umi_in_valid;
   logic [NCH*CW-1:0] umi_in_cmd;
   logic [NCH*AW-1:0] umi_in_dstaddr;
   logic [NCH*AW-1:0] umi_in_srcaddr;
   logic [NCH*DW-1:0] umi_in_data;
   logic [NCH-1:0]    umi_in_ready;
   logic [IOW-1:0]    phy_txdata;
   logic              phy_txvld;
   logic              phy_txrdy;
   logic [CHW-1:0]    phy_txch;
   logic              phy_txlast;

   always #5 clk = ~clk;

   lumi_tx_arb_ser #(.NCH(NCH), .IOW(IOW), .DW(DW), .CW(CW), .AW(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .csr_en         (csr_en),
      .csr_iowidth    (csr_iowidth),
      .umi_in_valid   (umi_in_valid),
      .umi_in_cmd     (umi_in_cmd),
      .umi_in_dstaddr (umi_in_dstaddr),
      .umi_in_srcaddr (umi_in_srcaddr),
      .umi_in_data    (umi_in_data),
      .umi_in_ready   (umi_in_ready),
      .phy_txdata     (phy_txdata),
      .phy_txvld      (phy_txvld),
      .phy_txrdy      (phy_txrdy),
      .phy_txch       (phy_txch),
      .phy_txlast     (phy_txlast)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [CW-1:0] f_cmd  [NCH];
   logic [AW-1:0] f_dst  [NCH];
   logic [AW-1:0] f_src  [NCH];
   logic [DW-1:0] f_data [NCH];

   logic [IOW-1:0] cap_data [64];
   logic           cap_last [64];
   logic [CHW-1:0] cap_ch   [64];
   int             cap_n;
   int             cap_unstable;
   int             cap_first_wait;
   bit             cap_timeout;

   task automatic apply_fields();
      for (int c = 0; c < NCH; c++) begin
         umi_in_cmd[c*CW +: CW]     = f_cmd[c];
         umi_in_dstaddr[c*AW +: AW] = f_dst[c];
         umi_in_srcaddr[c*AW +: AW] = f_src[c];
         umi_in_data[c*DW +: DW]    = f_data[c];
      end
   endtask

   function automatic logic [PKW-1:0] pkt_of(input int c);
      return {f_data[c], f_src[c], f_dst[c], f_cmd[c]};
   endfunction

   // Reference beat k for beat size 2^l bytes, built byte by byte.
   function automatic logic [IOW-1:0] exp_beat(input logic [PKW-1:0] pkt, input int l, input int k);
      logic [IOW-1:0] r;
      int bb;
      int idx;
      r  = '0;
      bb = 1 << l;
      for (int b = 0; b < IOW/8; b++) begin
         if (b < bb) begin
            idx = k*bb + b;
            if (idx < PB) r[8*b +: 8] = pkt[8*idx +: 8];
         end
      end
      return r;
   endfunction

   task automatic reset_dut();
      reset        = 1'b1;
      umi_in_valid = '0;
      phy_txrdy    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Raise valid on the channels in mask, wait for a ready pulse, drop valid.
   // Called and returns on a falling edge.
   task automatic inject(input logic [NCH-1:0] mask, output int granted, output bit ok);
      granted = -1;
      ok      = 1'b0;
      apply_fields();
      umi_in_valid = mask;
      for (int w = 0; w < 50; w++) begin
         #1;
         if (umi_in_ready != '0) begin
            ok = 1'b1;
            for (int c = 0; c < NCH; c++) if (umi_in_ready[c]) granted = c;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      umi_in_valid = '0;
   endtask

   // Collect accepted beats. mode 0: always ready; mode 1: random ready with
   // a forced 10-cycle stall at beat 2. act 1/2: at beat 2 set csr_iowidth=0 /
   // csr_en=0. Stops after the last beat or stop_n beats.
   task automatic capture(input int mode, input int act, input int stop_n);
      bit             prev_stall, seen_vld, done, stalled_once;
      int             stall_left;
      logic [IOW-1:0] p_data;
      logic           p_last, p_vld;
      logic [CHW-1:0] p_ch;
      cap_n = 0; cap_unstable = 0; cap_first_wait = 0; cap_timeout = 1'b0;
      prev_stall = 1'b0; seen_vld = 1'b0; done = 1'b0; stalled_once = 1'b0;
      stall_left = 0;
      p_data = '0; p_last = 1'b0; p_vld = 1'b0; p_ch = '0;
      for (int i = 0; i < 64; i++) begin
         cap_data[i] = 'x; cap_last[i] = 1'bx; cap_ch[i] = 'x;
      end
      for (int budget = 0; budget < 400 && !done; budget++) begin
         #1;
         if (prev_stall && (phy_txvld !== p_vld || phy_txdata !== p_data ||
                            phy_txlast !== p_last || phy_txch !== p_ch))
            cap_unstable++;
         if (!seen_vld) begin
            if (phy_txvld === 1'b1) seen_vld = 1'b1;
            else                    cap_first_wait++;
         end
         if (cap_n == 2 && act == 1) csr_iowidth = 8'd0;
         if (cap_n == 2 && act == 2) csr_en = 1'b0;
         if (mode == 0) begin
            phy_txrdy = 1'b1;
         end else begin
            if (cap_n == 2 && !stalled_once) begin
               stall_left   = 10;
               stalled_once = 1'b1;
            end
            if (stall_left > 0) begin
               phy_txrdy = 1'b0;
               stall_left--;
            end else begin
               phy_txrdy = 1'($urandom_range(0, 1));
            end
         end
         if (phy_txvld === 1'b1 && phy_txrdy) begin
            cap_data[cap_n] = phy_txdata;
            cap_last[cap_n] = phy_txlast;
            cap_ch[cap_n]   = phy_txch;
            cap_n++;
            if (phy_txlast === 1'b1 || cap_n >= stop_n || cap_n >= 64) done = 1'b1;
         end
         prev_stall = (phy_txvld === 1'b1) && !phy_txrdy;
         p_data = phy_txdata; p_last = phy_txlast; p_vld = phy_txvld; p_ch = phy_txch;
         @(negedge clk);
      end
      if (!done) cap_timeout = 1'b1;
      phy_txrdy = 1'b0;
   endtask

   task automatic test_reset();
      csr_en       = 1'b1;
      umi_in_valid = 2'b11;
      #1;
      n_checks++; if (phy_txvld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", phy_txvld); end
      n_checks++; if (phy_txlast !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", phy_txlast); end
      n_checks++; if (phy_txch !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %h expected 0", phy_txch); end
      n_checks++; if (phy_txdata !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", phy_txdata); end
      n_checks++; if (umi_in_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", umi_in_ready); end
      umi_in_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      n_checks++; if (phy_txvld !== 1'b0) begin n_fail++; $display("FAIL idle_vld: got %b expected 0", phy_txvld); end
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [IOW-1:0] exp [5];
      int  g;
      bit  ok;
      exp[0] = 64'h0000000A_11223344;
      exp[1] = 64'h0000000B_00000000;
      exp[2] = 64'h0000CAFE_00000000;
      exp[3] = 64'h0;
      exp[4] = 64'h0;
      f_cmd[1] = 32'h11223344; f_dst[1] = 64'hA; f_src[1] = 64'hB; f_data[1] = 128'hCAFE;
      csr_iowidth = 8'd3;
      inject(2'b10, g, ok);
      n_checks++; if (!ok || g != 1) begin n_fail++; $display("FAIL single_grant: got %0d expected 1", g); end
      capture(0, 0, 999);
      n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL single_timeout: got timeout expected last beat"); end
      n_checks++; if (cap_first_wait != 0) begin n_fail++; $display("FAIL single_latency: got %0d extra cycles expected 0", cap_first_wait); end
      n_checks++; if (cap_n != 5) begin n_fail++; $display("FAIL single_nbeats: got %0d expected 5", cap_n); end
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (cap_data[k] !== exp[k]) begin n_fail++; $display("FAIL single_beat%0d: got %h expected %h", k, cap_data[k], exp[k]); end
         n_checks++; if (cap_last[k] !== (k == 4)) begin n_fail++; $display("FAIL single_last%0d: got %b expected %b", k, cap_last[k], (k == 4)); end
         n_checks++; if (cap_ch[k] !== 1'b1) begin n_fail++; $display("FAIL single_ch%0d: got %h expected 1", k, cap_ch[k]); end
      end
   endtask

   task automatic test_width_sweep();
      int             lw [5] = '{0, 1, 2, 3, 7};
      int             nb [5] = '{36, 18, 9, 5, 5};
      int             g, l, bb, idx, last_bad;
      bit             ok;
      logic [PKW-1:0] pkt, rebuilt;
      f_cmd[0]  = 32'hA1B2C3D4;
      f_dst[0]  = 64'h0102030405060708;
      f_src[0]  = 64'h1112131415161718;
      f_data[0] = 128'h2122232425262728292A2B2C2D2E2F30;
      pkt = pkt_of(0);
      for (int t = 0; t < 5; t++) begin
         l  = (lw[t] > 3) ? 3 : lw[t];
         bb = 1 << l;
         csr_iowidth = 8'(lw[t]);
         inject(2'b01, g, ok);
         n_checks++; if (!ok || g != 0) begin n_fail++; $display("FAIL sweep%0d_grant: got %0d expected 0", lw[t], g); end
         capture(0, 0, 999);
         n_checks++; if (cap_n != nb[t]) begin n_fail++; $display("FAIL sweep%0d_nbeats: got %0d expected %0d", lw[t], cap_n, nb[t]); end
         rebuilt  = '0;
         last_bad = 0;
         for (int k = 0; k < nb[t]; k++) begin
            n_checks++; if (cap_data[k] !== exp_beat(pkt, l, k)) begin n_fail++; $display("FAIL sweep%0d_beat%0d: got %h expected %h", lw[t], k, cap_data[k], exp_beat(pkt, l, k)); end
            if (cap_last[k] !== (k == nb[t] - 1)) last_bad++;
            for (int b = 0; b < bb; b++) begin
               idx = k*bb + b;
               if (idx < PB) rebuilt[8*idx +: 8] = cap_data[k][8*b +: 8];
            end
         end
         n_checks++; if (last_bad != 0) begin n_fail++; $display("FAIL sweep%0d_last: got %0d misplaced expected 0", lw[t], last_bad); end
         n_checks++; if (rebuilt !== pkt) begin n_fail++; $display("FAIL sweep%0d_reassembly: got %h expected %h", lw[t], rebuilt, pkt); end
      end
   endtask

   task automatic test_round_robin();
      int       grants [8];
      int       txch   [8];
      int       ngr, pkts, beats, gap, width_bad, gap_bad, beats_bad;
      logic [NCH-1:0] prev_ready;
      reset_dut();
      f_cmd[0] = 32'h0000C0C0; f_dst[0] = 64'h10; f_src[0] = 64'h20; f_data[0] = 128'h30;
      f_cmd[1] = 32'h0000C1C1; f_dst[1] = 64'h11; f_src[1] = 64'h21; f_data[1] = 128'h31;
      csr_iowidth = 8'd3;
      csr_en      = 1'b1;
      apply_fields();
      umi_in_valid = 2'b11;
      phy_txrdy    = 1'b1;
      ngr = 0; pkts = 0; beats = 0; gap = 0; width_bad = 0; gap_bad = 0; beats_bad = 0;
      prev_ready = '0;
      for (int i = 0; i < 8; i++) begin grants[i] = -1; txch[i] = -1; end
      for (int cyc = 0; cyc < 200 && pkts < 8; cyc++) begin
         #1;
         if (umi_in_ready != '0) begin
            if ($countones(umi_in_ready) != 1 || prev_ready != '0) width_bad++;
            if (ngr < 8) grants[ngr] = umi_in_ready[1] ? 1 : 0;
            ngr++;
         end
         prev_ready = umi_in_ready;
         if (phy_txvld === 1'b1) begin
            if (beats == 0 && pkts > 0 && gap != 1) gap_bad++;
            gap = 0;
            beats++;
            if (phy_txlast === 1'b1) begin
               txch[pkts] = int'(phy_txch);
               if (beats != 5) beats_bad++;
               beats = 0;
               pkts++;
               if (pkts == 8) umi_in_valid = '0;
            end
         end else begin
            gap++;
         end
         @(negedge clk);
      end
      phy_txrdy = 1'b0;
      n_checks++; if (pkts != 8) begin n_fail++; $display("FAIL rr_packets: got %0d expected 8", pkts); end
      n_checks++; if (ngr != 8) begin n_fail++; $display("FAIL rr_grants: got %0d expected 8", ngr); end
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (grants[i] != i % 2) begin n_fail++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, grants[i], i % 2); end
         n_checks++; if (txch[i] != i % 2) begin n_fail++; $display("FAIL rr_txch%0d: got %0d expected %0d", i, txch[i], i % 2); end
      end
      n_checks++; if (width_bad != 0) begin n_fail++; $display("FAIL rr_ready_pulse: got %0d bad pulses expected 0", width_bad); end
      n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL rr_idle_gap: got %0d bad gaps expected 0", gap_bad); end
      n_checks++; if (beats_bad != 0) begin n_fail++; $display("FAIL rr_beats: got %0d bad packets expected 0", beats_bad); end
   endtask

   task automatic test_backpressure();
      int             lw [2] = '{3, 1};
      int             nb [2] = '{5, 18};
      int             g, ch_bad;
      bit             ok;
      logic [PKW-1:0] pkt;
      f_cmd[1]  = 32'hDEADBEEF;
      f_dst[1]  = 64'h8877665544332211;
      f_src[1]  = 64'hFFEEDDCCBBAA9988;
      f_data[1] = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      pkt = pkt_of(1);
      for (int t = 0; t < 2; t++) begin
         csr_iowidth = 8'(lw[t]);
         inject(2'b10, g, ok);
         n_checks++; if (!ok || g != 1) begin n_fail++; $display("FAIL bp%0d_grant: got %0d expected 1", t, g); end
         capture(1, 0, 999);
         n_checks++; if (cap_n != nb[t]) begin n_fail++; $display("FAIL bp%0d_nbeats: got %0d expected %0d", t, cap_n, nb[t]); end
         n_checks++; if (cap_unstable != 0) begin n_fail++; $display("FAIL bp%0d_stable: got %0d changes while stalled expected 0", t, cap_unstable); end
         ch_bad = 0;
         for (int k = 0; k < nb[t]; k++) begin
            if (cap_ch[k] !== 1'b1) ch_bad++;
            n_checks++; if (cap_data[k] !== exp_beat(pkt, lw[t], k)) begin n_fail++; $display("FAIL bp%0d_beat%0d: got %h expected %h", t, k, cap_data[k], exp_beat(pkt, lw[t], k)); end
         end
         n_checks++; if (ch_bad != 0) begin n_fail++; $display("FAIL bp%0d_ch: got %0d wrong expected 0", t, ch_bad); end
      end
   endtask

   task automatic test_controls();
      int             g, rdy_bad;
      bit             ok;
      logic [PKW-1:0] pkt;
      // Beat width change mid-packet has no effect on the packet in flight.
      csr_en = 1'b1;
      csr_iowidth = 8'd3;
      pkt = pkt_of(0);
      inject(2'b01, g, ok);
      n_checks++; if (!ok || g != 0) begin n_fail++; $display("FAIL ctl_w_grant: got %0d expected 0", g); end
      capture(0, 1, 999);
      n_checks++; if (cap_n != 5) begin n_fail++; $display("FAIL ctl_w_nbeats: got %0d expected 5", cap_n); end
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (cap_data[k] !== exp_beat(pkt, 3, k)) begin n_fail++; $display("FAIL ctl_w_beat%0d: got %h expected %h", k, cap_data[k], exp_beat(pkt, 3, k)); end
      end
      // Enable dropped mid-packet: packet completes, no further grants.
      csr_iowidth = 8'd3;
      pkt = pkt_of(1);
      inject(2'b10, g, ok);
      n_checks++; if (!ok || g != 1) begin n_fail++; $display("FAIL ctl_en_grant: got %0d expected 1", g); end
      capture(0, 2, 999);
      n_checks++; if (cap_n != 5) begin n_fail++; $display("FAIL ctl_en_nbeats: got %0d expected 5", cap_n); end
      n_checks++; if (cap_data[4] !== exp_beat(pkt, 3, 4) || cap_last[4] !== 1'b1) begin n_fail++; $display("FAIL ctl_en_final: got %h/%b expected %h/1", cap_data[4], cap_last[4], exp_beat(pkt, 3, 4)); end
      umi_in_valid = 2'b11;
      rdy_bad = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (umi_in_ready !== 2'b00 || phy_txvld !== 1'b0) rdy_bad++;
         @(negedge clk);
      end
      n_checks++; if (rdy_bad != 0) begin n_fail++; $display("FAIL ctl_en_ready: got %0d cycles with activity expected 0", rdy_bad); end
      umi_in_valid = '0;
      csr_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      int             g;
      bit             ok;
      logic [PKW-1:0] pkt;
      csr_iowidth = 8'd3;
      inject(2'b01, g, ok);
      n_checks++; if (!ok || g != 0) begin n_fail++; $display("FAIL arst_pre_grant: got %0d expected 0", g); end
      capture(0, 0, 2);
      n_checks++; if (phy_txvld !== 1'b1) begin n_fail++; $display("FAIL arst_midpkt_vld: got %b expected 1", phy_txvld); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (phy_txvld !== 1'b0) begin n_fail++; $display("FAIL arst_vld: got %b expected 0", phy_txvld); end
      n_checks++; if (phy_txlast !== 1'b0) begin n_fail++; $display("FAIL arst_last: got %b expected 0", phy_txlast); end
      n_checks++; if (phy_txdata !== '0) begin n_fail++; $display("FAIL arst_data: got %h expected 0", phy_txdata); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pkt = pkt_of(0);
      inject(2'b11, g, ok);
      n_checks++; if (!ok || g != 0) begin n_fail++; $display("FAIL arst_post_grant: got %0d expected 0", g); end
      capture(0, 0, 999);
      n_checks++; if (cap_n != 5) begin n_fail++; $display("FAIL arst_nbeats: got %0d expected 5", cap_n); end
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (cap_data[k] !== exp_beat(pkt, 3, k) || cap_ch[k] !== 1'b0) begin n_fail++; $display("FAIL arst_beat%0d: got %h ch %h expected %h ch 0", k, cap_data[k], cap_ch[k], exp_beat(pkt, 3, k)); end
      end
   endtask

   initial begin
      reset          = 1'b1;
      csr_en         = 1'b0;
      csr_iowidth    = 8'd3;
      umi_in_valid   = '0;
      umi_in_cmd     = '0;
      umi_in_dstaddr = '0;
      umi_in_srcaddr = '0;
      umi_in_data    = '0;
      phy_txrdy      = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         f_cmd[c] = '0; f_dst[c] = '0; f_src[c] = '0; f_data[c] = '0;
      end
      @(negedge clk);
      test_reset();
      test_single();
      test_width_sweep();
      test_round_robin();
      test_backpressure();
      test_controls();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within 500000 time units");
      $fatal(1, "simulation watchdog expired");
   end

endmodule
